// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: owns the thread register file, reads
// sources (with writeback bypass) or selects an immediate, and holds one entry.
module alu_operand_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int IMM_WIDTH  = 8,
  parameter int THREAD_ID  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_rd,
  input  logic [3:0]            in_rs,
  input  logic [3:0]            in_rt,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic                  in_use_imm,
  input  logic [DATA_WIDTH-1:0] block_idx,
  input  logic [DATA_WIDTH-1:0] block_dim,
  input  logic                  wb_en,
  input  logic [3:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_opcode,
  output logic [DATA_WIDTH-1:0] out_operand_a,
  output logic [DATA_WIDTH-1:0] out_operand_b,
  output logic [3:0]            out_rd
);

  localparam int NUM_RW = 13;
  localparam logic [DATA_WIDTH-1:0] TID_VAL = DATA_WIDTH'(THREAD_ID);

  // Full 16-entry read view: r0..r12 from flops, r13..r15 from live inputs.
  logic [DATA_WIDTH-1:0] rf_view [16];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q;
      logic [DATA_WIDTH-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (wb_en && (wb_rd == 4'(gi))) reg_d = wb_data;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) reg_q <= '0;
        else       reg_q <= reg_d;
      end

      assign rf_view[gi] = reg_q;
    end
  endgenerate

  assign rf_view[13] = block_idx;
  assign rf_view[14] = block_dim;
  assign rf_view[15] = TID_VAL;

  function automatic logic [DATA_WIDTH-1:0] read_src(input logic [3:0] addr);
    if (wb_en && (wb_rd <= 4'd12) && (wb_rd == addr)) return wb_data;
    return rf_view[addr];
  endfunction

  logic                  out_valid_q, out_valid_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [3:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic                  capture;

  always_comb begin
    in_ready    = !flush && (!out_valid_q || out_ready);
    capture     = in_valid && in_ready;
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      opcode_d    = in_opcode;
      rd_d        = in_rd;
      opa_d       = read_src(in_rs);
      opb_d       = in_use_imm ? DATA_WIDTH'(in_imm) : read_src(in_rt);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = opcode_q;
  assign out_rd        = rd_q;
  assign out_operand_a = opa_q;
  assign out_operand_b = opb_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomised scoreboard bench for alu_operand_fetch: a driver predicts each
// captured entry from an architectural register model, a monitor checks outputs.
module tb_alu_operand_fetch;

  localparam int DW  = 8;
  localparam int IW  = 8;
  localparam int TID = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [IW-1:0] in_imm = '0;
  logic          in_use_imm = 1'b0;
  logic [DW-1:0] block_idx = 8'h02, block_dim = 8'h33;
  logic          wb_en = 1'b0;
  logic [3:0]    wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_opcode, out_rd;
  logic [DW-1:0] out_operand_a, out_operand_b;

  alu_operand_fetch #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .THREAD_ID(TID)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .block_idx(block_idx), .block_dim(block_dim),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand_a(out_operand_a),
    .out_operand_b(out_operand_b), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    rd;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] mregs[13];
  bit            mvalid = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            issued = 0;
  int            received = 0;

  // Architectural value of a source read in a given cycle, writeback included.
  function automatic logic [DW-1:0] src_val(input int r, input logic we,
                                            input logic [3:0] wr, input logic [DW-1:0] wd);
    if (r == 13) return block_idx;
    if (r == 14) return block_dim;
    if (r == 15) return DW'(TID);
    if (we && int'(wr) == r) return wd;
    return mregs[r];
  endfunction

  task automatic cycle(input logic iv, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt, input logic [IW-1:0] imm,
                       input logic ui, input logic we, input logic [3:0] wr,
                       input logic [DW-1:0] wd, input logic ordy, input logic fl);
    bit   exp_rdy, cap;
    ent_t e;
    @(negedge clk);
    in_valid = iv; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm = imm; in_use_imm = ui; wb_en = we; wb_rd = wr; wb_data = wd;
    out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (!mvalid || ordy);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b (t=%0t)", in_ready, exp_rdy, $time);
    end
    cap = iv && exp_rdy;
    e.op = op;
    e.rd = rd;
    e.a  = src_val(int'(rs), we, wr, wd);
    e.b  = ui ? DW'(imm) : src_val(int'(rt), we, wr, wd);
    @(posedge clk);
    if (fl) begin
      mvalid = 1'b0;
      exp_q.delete();
    end else if (cap) begin
      exp_q.push_back(e);
      mvalid = 1'b1;
      issued++;
      $display("issue op=%h rd=%h a=%h b=%h", e.op, e.rd, e.a, e.b);
    end else if (ordy) begin
      mvalid = 1'b0;
    end
    if (we && wr <= 4'd12) mregs[wr] = wd;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, '0, 1'b0, 1'b0, 4'h0, '0, ordy, 1'b0);
  endtask

  task automatic wb_write(input logic [3:0] r, input logic [DW-1:0] d);
    cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, '0, 1'b0, 1'b1, r, d, 1'b1, 1'b0);
  endtask

  task automatic rand_cycle(input int ready_pct, input int flush_pct);
    logic ordy, fl;
    fl   = ($urandom_range(99) < flush_pct);
    ordy = fl ? 1'b0 : ($urandom_range(99) < ready_pct);
    cycle($urandom_range(99) < 70, 4'($urandom), 4'($urandom), 4'($urandom),
          4'($urandom), IW'($urandom), 1'($urandom), $urandom_range(99) < 50,
          4'($urandom), DW'($urandom), ordy, fl);
  endtask

  // Monitor: compares the presented entry with the scoreboard head every cycle.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      checks++;
      if (out_valid !== mvalid) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid, mvalid, $time);
      end
      if (mvalid && exp_q.size() > 0) begin
        checks++;
        if ({out_opcode, out_operand_a, out_operand_b, out_rd} !== exp_q[0]) begin
          errors++;
          $display("FAIL entry: got op=%h a=%h b=%h rd=%h expected op=%h a=%h b=%h rd=%h",
                   out_opcode, out_operand_a, out_operand_b, out_rd,
                   exp_q[0].op, exp_q[0].a, exp_q[0].b, exp_q[0].rd);
        end
        if (out_ready) begin
          $display("recv  op=%h rd=%h a=%h b=%h", out_opcode, out_rd, out_operand_a, out_operand_b);
          void'(exp_q.pop_front());
          received++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 13; i++) mregs[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_opcode, out_operand_a, out_operand_b, out_rd} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b op=%h a=%h b=%h rd=%h expected all zero",
               out_valid, out_opcode, out_operand_a, out_operand_b, out_rd);
    end

    // Basic register read.
    wb_write(4'd3, 8'h12);
    wb_write(4'd4, 8'h05);
    cycle(1, 4'h0, 4'd7, 4'd3, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    // Immediate, special registers, ignored write to r14.
    cycle(1, 4'h1, 4'd8, 4'd3, 4'd9, 8'h7F, 1, 0, 4'd0, 8'h00, 1, 0);
    cycle(1, 4'hE, 4'd2, 4'd13, 4'd15, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    cycle(1, 4'hF, 4'd1, 4'd14, 4'd14, 8'h00, 0, 1, 4'd14, 8'h99, 1, 0);
    cycle(1, 4'h2, 4'd1, 4'd14, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    // Same-cycle bypass on both operands, then array read.
    cycle(1, 4'h3, 4'd5, 4'd5, 4'd5, 8'h00, 0, 1, 4'd5, 8'hAA, 1, 0);
    cycle(1, 4'h4, 4'd6, 4'd5, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    idle(1);

    // Back-pressure: held entry must not follow later writes to its sources.
    cycle(1, 4'h5, 4'd9, 4'd3, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 4'h6, 4'd10, 4'd3, 4'd4, 8'h00, 0, 1, 4'(3 + (i % 2)), DW'(8'h40 + i), 0, 0);
    cycle(1, 4'h6, 4'd10, 4'd3, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    idle(1);

    // Flush while stalled with a pending input.
    cycle(1, 4'h7, 4'd11, 4'd1, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    cycle(1, 4'h8, 4'd12, 4'd1, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    cycle(1, 4'h9, 4'd12, 4'd1, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1);
    idle(1);

    // Twenty-instruction stream under random ready, no flush.
    begin
      int start;
      start = issued;
      for (int n = 0; n < 400 && issued - start < 20; n++) rand_cycle(60, 0);
    end
    for (int i = 0; i < 4; i++) idle(1);

    // Long random run including flushes.
    for (int n = 0; n < 400; n++) rand_cycle(65, 4);
    idle(1);

    // Async reset between edges while an entry is stalled.
    cycle(1, 4'hA, 4'd3, 4'd3, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
    #3;
    reset = 1'b1;
    mvalid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 13; i++) mregs[i] = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_valid got %b expected 0", out_valid);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 13; r += 2)
      cycle(1, 4'hB, 4'(r), 4'(r), 4'((r + 1) % 13), 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) idle(1);

    checks++;
    if (exp_q.size() != 0 || issued != received + 0 && exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
